// File: rtl/decode_pipe_if.sv
// decode_pipe_if: fetch-side and execute-side handshake bundle of the
// decode stage.
//   in_valid/in_ready/in_data/in_pc   : instruction stream from fetch
//   out_valid/out_ready/out_*         : micro-op stream towards execute
// The master modport drives instructions and consumes micro-ops.
// The decode stage itself uses the slave modport.
interface decode_pipe_if #(
    parameter int KIND_W = 6
) ();
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic [31:0]       in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [KIND_W-1:0] out_kind;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [31:0]       out_imm;
    logic [31:0]       out_pc;
    logic              out_illegal;

    modport master (
        output in_valid, in_data, in_pc, out_ready,
        input  in_ready, out_valid, out_kind, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_data, in_pc, out_ready,
        output in_ready, out_valid, out_kind, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_illegal
    );
endinterface

// File: rtl/decode_pipe.sv
// decode_pipe: RV32 decode stage. Decodes one instruction per cycle into a
// micro-op and buffers it in a FIFO_DEPTH-entry output FIFO. Illegal words
// become trap micro-ops and latch a sticky error (cause + PC).
// Ports:
//   clock, reset     : clock, synchronous active-high reset
//   bus (slave)      : in_* from fetch, out_* towards execute
//   flush            : drop buffered uops and refuse input this cycle
//   err_pending/err_cause/err_pc/err_clear : sticky illegal-instruction latch
//   decoded_count    : number of accepted legal instructions (wraps)
module decode_pipe #(
    parameter int NUM_REGS   = 16,
    parameter int FIFO_DEPTH = 2,
    parameter int KIND_W     = 6,
    parameter int ERR_STALL  = 0
) (
    input  logic         clock,
    input  logic         reset,
    decode_pipe_if.slave bus,
    input  logic         flush,
    output logic         err_pending,
    output logic [2:0]   err_cause,
    output logic [31:0]  err_pc,
    input  logic         err_clear,
    output logic [31:0]  decoded_count
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011;
    localparam logic [6:0] OPC_MISC = 7'b0001111, OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] F7_ZERO = 7'b0000000, F7_ALT = 7'b0100000;

    // instruction_kind encoding, numbered from 0 in this order
    typedef enum logic [5:0] {
        INST_NOP, INST_LUI, INST_AUIPC, INST_JAL, INST_JALR,
        INST_BEQ, INST_BNE, INST_BLT, INST_BGE, INST_BLTU, INST_BGEU,
        INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU, INST_SB, INST_SH, INST_SW,
        INST_ADDI, INST_SLTI, INST_SLTIU, INST_XORI, INST_ORI, INST_ANDI,
        INST_SLLI, INST_SRLI, INST_SRAI, INST_ADD, INST_SUB, INST_SLL, INST_SLT,
        INST_SLTU, INST_XOR, INST_SRL, INST_SRA, INST_OR, INST_AND
    } instruction_kind_e;

    typedef struct packed {
        logic              illegal;
        logic [KIND_W-1:0] kind;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [31:0]       imm;
        logic [31:0]       pc;
    } uop_t;

    function automatic logic reg_out_of_range(input logic [4:0] idx);
        reg_out_of_range = ({27'd0, idx} >= 32'(NUM_REGS));
    endfunction

    uop_t              mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              err_pending_r;
    logic [2:0]        err_cause_r;
    logic [31:0]       err_pc_r, decoded_count_r;

    logic [31:0]       d_s;
    instruction_kind_e kind_s;
    logic [31:0]       imm_s;
    logic              use_rd_s, use_rs1_s, use_rs2_s;
    logic              bad_op_s, bad_f3_s, bad_f7_s, bad_reg_s;
    logic [2:0]        cause_s;
    uop_t              entry_s, head_s;
    logic              in_ready_s, out_valid_s, push_s, pop_s;

    assign d_s         = bus.in_data;
    assign out_valid_s = (count_r != CNT_W'(1'b0));
    // No pass-through: a full FIFO refuses input even if it pops this cycle.
    assign in_ready_s  = (count_r < CNT_W'(FIFO_DEPTH)) && !((ERR_STALL != 0) && err_pending_r) && !flush;
    assign push_s      = bus.in_valid && in_ready_s;
    assign pop_s       = out_valid_s && bus.out_ready && !flush;

    // Decode opcode/funct fields into a kind, immediate and register usage.
    always_comb begin
        kind_s    = INST_NOP;
        imm_s     = 32'd0;
        use_rd_s  = 1'b0;
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        bad_op_s  = 1'b0;
        bad_f3_s  = 1'b0;
        bad_f7_s  = 1'b0;
        case (d_s[6:0])
            OPC_LUI, OPC_AUIPC: begin
                kind_s   = (d_s[6:0] == OPC_LUI) ? INST_LUI : INST_AUIPC;
                use_rd_s = 1'b1;
                imm_s    = {d_s[31:12], 12'd0};
            end
            OPC_JAL: begin
                kind_s   = INST_JAL;
                use_rd_s = 1'b1;
                imm_s    = {{11{d_s[31]}}, d_s[31], d_s[19:12], d_s[20], d_s[30:21], 1'b0};
            end
            OPC_JALR: begin
                kind_s    = INST_JALR;
                use_rd_s  = 1'b1;
                use_rs1_s = 1'b1;
                imm_s     = {{20{d_s[31]}}, d_s[31:20]};
                bad_f3_s  = (d_s[14:12] != 3'b000);
            end
            OPC_BRANCH: begin
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                imm_s     = {{19{d_s[31]}}, d_s[31], d_s[7], d_s[30:25], d_s[11:8], 1'b0};
                case (d_s[14:12])
                    3'b000:  kind_s = INST_BEQ;
                    3'b001:  kind_s = INST_BNE;
                    3'b100:  kind_s = INST_BLT;
                    3'b101:  kind_s = INST_BGE;
                    3'b110:  kind_s = INST_BLTU;
                    3'b111:  kind_s = INST_BGEU;
                    default: bad_f3_s = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                use_rd_s  = 1'b1;
                use_rs1_s = 1'b1;
                imm_s     = {{20{d_s[31]}}, d_s[31:20]};
                case (d_s[14:12])
                    3'b000:  kind_s = INST_LB;
                    3'b001:  kind_s = INST_LH;
                    3'b010:  kind_s = INST_LW;
                    3'b100:  kind_s = INST_LBU;
                    3'b101:  kind_s = INST_LHU;
                    default: bad_f3_s = 1'b1;
                endcase
            end
            OPC_STORE: begin
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                imm_s     = {{20{d_s[31]}}, d_s[31:25], d_s[11:7]};
                case (d_s[14:12])
                    3'b000:  kind_s = INST_SB;
                    3'b001:  kind_s = INST_SH;
                    3'b010:  kind_s = INST_SW;
                    default: bad_f3_s = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                use_rd_s  = 1'b1;
                use_rs1_s = 1'b1;
                imm_s     = {{20{d_s[31]}}, d_s[31:20]};
                case (d_s[14:12])
                    3'b000:  kind_s = INST_ADDI;
                    3'b010:  kind_s = INST_SLTI;
                    3'b011:  kind_s = INST_SLTIU;
                    3'b100:  kind_s = INST_XORI;
                    3'b110:  kind_s = INST_ORI;
                    3'b111:  kind_s = INST_ANDI;
                    3'b001: begin
                        kind_s   = INST_SLLI;
                        imm_s    = {27'd0, d_s[24:20]};
                        bad_f7_s = (d_s[31:25] != F7_ZERO);
                    end
                    default: begin
                        kind_s   = (d_s[31:25] == F7_ALT) ? INST_SRAI : INST_SRLI;
                        imm_s    = {27'd0, d_s[24:20]};
                        bad_f7_s = (d_s[31:25] != F7_ZERO) && (d_s[31:25] != F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                use_rd_s  = 1'b1;
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                bad_f7_s  = (d_s[31:25] != F7_ZERO);
                case (d_s[14:12])
                    3'b000: begin
                        kind_s   = (d_s[31:25] == F7_ALT) ? INST_SUB : INST_ADD;
                        bad_f7_s = (d_s[31:25] != F7_ZERO) && (d_s[31:25] != F7_ALT);
                    end
                    3'b101: begin
                        kind_s   = (d_s[31:25] == F7_ALT) ? INST_SRA : INST_SRL;
                        bad_f7_s = (d_s[31:25] != F7_ZERO) && (d_s[31:25] != F7_ALT);
                    end
                    3'b001:  kind_s = INST_SLL;
                    3'b010:  kind_s = INST_SLT;
                    3'b011:  kind_s = INST_SLTU;
                    3'b100:  kind_s = INST_XOR;
                    3'b110:  kind_s = INST_OR;
                    default: kind_s = INST_AND;
                endcase
            end
            OPC_MISC, OPC_SYSTEM: kind_s = INST_NOP;
            default: bad_op_s = 1'b1;
        endcase
    end

    // Prioritise the legality checks and build the micro-op to push.
    always_comb begin
        bad_reg_s = (use_rd_s && reg_out_of_range(d_s[11:7])) ||
                    (use_rs1_s && reg_out_of_range(d_s[19:15])) ||
                    (use_rs2_s && reg_out_of_range(d_s[24:20]));
        if (bad_op_s) begin
            cause_s = 3'd1;
        end else if (bad_f3_s) begin
            cause_s = 3'd2;
        end else if (bad_f7_s) begin
            cause_s = 3'd3;
        end else if (bad_reg_s) begin
            cause_s = 3'd4;
        end else begin
            cause_s = 3'd0;
        end
        entry_s.pc = bus.in_pc;
        if (cause_s != 3'd0) begin
            entry_s.illegal = 1'b1;
            entry_s.kind    = KIND_W'(INST_NOP);
            entry_s.rd      = 5'd0;
            entry_s.rs1     = 5'd0;
            entry_s.rs2     = 5'd0;
            entry_s.imm     = d_s;
        end else begin
            entry_s.illegal = 1'b0;
            entry_s.kind    = KIND_W'(kind_s);
            entry_s.rd      = use_rd_s  ? d_s[11:7]  : 5'd0;
            entry_s.rs1     = use_rs1_s ? d_s[19:15] : 5'd0;
            entry_s.rs2     = use_rs2_s ? d_s[24:20] : 5'd0;
            entry_s.imm     = imm_s;
        end
    end

    // FIFO storage; stale entries are masked by the occupancy count.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error latch; a new illegal beats a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_pending_r <= 1'b0;
            err_cause_r   <= 3'd0;
            err_pc_r      <= 32'd0;
        end else if (push_s && entry_s.illegal && (!err_pending_r || err_clear)) begin
            err_pending_r <= 1'b1;
            err_cause_r   <= cause_s;
            err_pc_r      <= bus.in_pc;
        end else if (err_clear) begin
            err_pending_r <= 1'b0;
            err_cause_r   <= 3'd0;
            err_pc_r      <= 32'd0;
        end
    end

    // Count accepted legal instructions.
    always_ff @(posedge clock) begin
        if (reset) begin
            decoded_count_r <= 32'd0;
        end else if (push_s && !entry_s.illegal) begin
            decoded_count_r <= decoded_count_r + 32'd1;
        end
    end

    // Head of FIFO, forced to zero while empty.
    always_comb begin
        if (out_valid_s) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = {$bits(uop_t){1'b0}};
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_s;
    assign bus.out_kind    = head_s.kind;
    assign bus.out_rd      = head_s.rd;
    assign bus.out_rs1     = head_s.rs1;
    assign bus.out_rs2     = head_s.rs2;
    assign bus.out_imm     = head_s.imm;
    assign bus.out_pc      = head_s.pc;
    assign bus.out_illegal = head_s.illegal;
    assign err_pending     = err_pending_r;
    assign err_cause       = err_cause_r;
    assign err_pc          = err_pc_r;
    assign decoded_count   = decoded_count_r;
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed bench for decode_pipe. Three instances share one
// stimulus stream: u16 (NUM_REGS=16), u32 (NUM_REGS=32) and ust (ERR_STALL=1).
module tb_decode_pipe;
    logic clock = 1'b0;
    logic reset, flush, err_clear;
    logic drv_valid, drv_oready;
    logic [31:0] drv_data, drv_pc;
    int total = 0;
    int bad = 0;

    logic ep16, ep32, epst;
    logic [2:0] ec16, ec32, ecst;
    logic [31:0] epc16, epc32, epcst, dc16, dc32, dcst;

    decode_pipe_if #(.KIND_W(6)) b16 ();
    decode_pipe_if #(.KIND_W(6)) b32 ();
    decode_pipe_if #(.KIND_W(6)) bst ();

    assign b16.in_valid = drv_valid; assign b16.in_data = drv_data;
    assign b16.in_pc = drv_pc;       assign b16.out_ready = drv_oready;
    assign b32.in_valid = drv_valid; assign b32.in_data = drv_data;
    assign b32.in_pc = drv_pc;       assign b32.out_ready = drv_oready;
    assign bst.in_valid = drv_valid; assign bst.in_data = drv_data;
    assign bst.in_pc = drv_pc;       assign bst.out_ready = drv_oready;

    decode_pipe #(.NUM_REGS(16), .FIFO_DEPTH(2), .KIND_W(6), .ERR_STALL(0)) u16 (
        .clock(clock), .reset(reset), .bus(b16.slave), .flush(flush), .err_pending(ep16),
        .err_cause(ec16), .err_pc(epc16), .err_clear(err_clear), .decoded_count(dc16));
    decode_pipe #(.NUM_REGS(32), .FIFO_DEPTH(2), .KIND_W(6), .ERR_STALL(0)) u32 (
        .clock(clock), .reset(reset), .bus(b32.slave), .flush(flush), .err_pending(ep32),
        .err_cause(ec32), .err_pc(epc32), .err_clear(err_clear), .decoded_count(dc32));
    decode_pipe #(.NUM_REGS(16), .FIFO_DEPTH(2), .KIND_W(6), .ERR_STALL(1)) ust (
        .clock(clock), .reset(reset), .bus(bst.slave), .flush(flush), .err_pending(epst),
        .err_cause(ecst), .err_pc(epcst), .err_clear(err_clear), .decoded_count(dcst));

    always #5 clock = ~clock;

    // kinds: NOP=0 LUI=1 JAL=3 BNE=6 SW=18 ADDI=19 SRAI=27 ADD=28 SUB=29
    localparam logic [31:0] ADDI_X1 = 32'h00100093, ADDI_X2 = 32'h00200113, ADDI_X3 = 32'h00300193;
    localparam logic [31:0] BAD_OPC = 32'h0000007F;
    // LUI x7; JAL x1,+16; SW x2,8(x1); BNE x1,x2,-4; SRAI x3,x4,5; SUB x5,x6,x7; FENCE
    localparam logic [31:0] BB_WORD [7] = '{32'h123453B7, 32'h010000EF, 32'h0020A423,
        32'hFE209EE3, 32'h40525193, 32'h407302B3, 32'h0FF0000F};
    localparam logic [5:0]  BB_KIND [7] = '{6'd1, 6'd3, 6'd18, 6'd6, 6'd27, 6'd29, 6'd0};
    localparam logic [4:0]  BB_RD   [7] = '{5'd7, 5'd1, 5'd0, 5'd0, 5'd3, 5'd5, 5'd0};
    localparam logic [4:0]  BB_RS1  [7] = '{5'd0, 5'd0, 5'd1, 5'd1, 5'd4, 5'd6, 5'd0};
    localparam logic [4:0]  BB_RS2  [7] = '{5'd0, 5'd0, 5'd2, 5'd2, 5'd0, 5'd7, 5'd0};
    localparam logic [31:0] BB_IMM  [7] = '{32'h12345000, 32'h00000010, 32'h00000008,
        32'hFFFFFFFC, 32'h00000005, 32'h00000000, 32'h00000000};

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; err_clear = 1'b0;
        drv_valid = 1'b0; drv_oready = 1'b0; drv_data = 32'd0; drv_pc = 32'd0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drv_valid = 1'b1; drv_data = BAD_OPC; drv_pc = 32'h4;
        tick();
        drv_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0h exp=0", b16.out_valid); end
        total++; if (b16.out_illegal !== 1'b0) begin bad++; $display("FAIL rst_out_illegal got=%0h exp=0", b16.out_illegal); end
        total++; if (b16.out_imm !== 32'd0) begin bad++; $display("FAIL rst_out_imm got=%0h exp=0", b16.out_imm); end
        total++; if (b16.out_pc !== 32'd0) begin bad++; $display("FAIL rst_out_pc got=%0h exp=0", b16.out_pc); end
        total++; if (ep16 !== 1'b0) begin bad++; $display("FAIL rst_err_pending got=%0h exp=0", ep16); end
        total++; if (ec16 !== 3'd0) begin bad++; $display("FAIL rst_err_cause got=%0h exp=0", ec16); end
        total++; if (epc16 !== 32'd0) begin bad++; $display("FAIL rst_err_pc got=%0h exp=0", epc16); end
        total++; if (dc16 !== 32'd0) begin bad++; $display("FAIL rst_count got=%0h exp=0", dc16); end
        total++; if (b16.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0h exp=1", b16.in_ready); end
    endtask

    task automatic test_addi();
        do_reset();
        drv_oready = 1'b1; drv_valid = 1'b1; drv_data = 32'hFFD08293; drv_pc = 32'h100;
        tick();
        drv_valid = 1'b0;
        total++; if (b16.out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%0h exp=1", b16.out_valid); end
        total++; if (b16.out_kind !== 6'd19) begin bad++; $display("FAIL addi_kind got=%0d exp=19", b16.out_kind); end
        total++; if (b16.out_rd !== 5'd5) begin bad++; $display("FAIL addi_rd got=%0d exp=5", b16.out_rd); end
        total++; if (b16.out_rs1 !== 5'd1) begin bad++; $display("FAIL addi_rs1 got=%0d exp=1", b16.out_rs1); end
        total++; if (b16.out_rs2 !== 5'd0) begin bad++; $display("FAIL addi_rs2 got=%0d exp=0", b16.out_rs2); end
        total++; if (b16.out_imm !== 32'hFFFFFFFD) begin bad++; $display("FAIL addi_imm got=%0h exp=fffffffd", b16.out_imm); end
        total++; if (b16.out_illegal !== 1'b0) begin bad++; $display("FAIL addi_illegal got=%0h exp=0", b16.out_illegal); end
        total++; if (b16.out_pc !== 32'h100) begin bad++; $display("FAIL addi_pc got=%0h exp=100", b16.out_pc); end
        total++; if (dc16 !== 32'd1) begin bad++; $display("FAIL addi_count got=%0d exp=1", dc16); end
        tick();
        total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL addi_drained got=%0h exp=0", b16.out_valid); end
        total++; if (b16.out_kind !== 6'd0) begin bad++; $display("FAIL addi_empty_kind got=%0d exp=0", b16.out_kind); end
    endtask

    // 0x011008B3 is ADD rd=x17, rs1=x0, rs2=x17.
    task automatic test_reg_range();
        do_reset();
        drv_oready = 1'b1; drv_valid = 1'b1; drv_data = 32'h011008B3; drv_pc = 32'h40;
        tick();
        drv_valid = 1'b0;
        total++; if (b16.out_illegal !== 1'b1) begin bad++; $display("FAIL rr16_illegal got=%0h exp=1", b16.out_illegal); end
        total++; if (b16.out_kind !== 6'd0) begin bad++; $display("FAIL rr16_kind got=%0d exp=0", b16.out_kind); end
        total++; if (b16.out_rd !== 5'd0) begin bad++; $display("FAIL rr16_rd got=%0d exp=0", b16.out_rd); end
        total++; if (b16.out_imm !== 32'h011008B3) begin bad++; $display("FAIL rr16_imm got=%0h exp=011008b3", b16.out_imm); end
        total++; if (b16.out_pc !== 32'h40) begin bad++; $display("FAIL rr16_pc got=%0h exp=40", b16.out_pc); end
        total++; if (ep16 !== 1'b1) begin bad++; $display("FAIL rr16_pending got=%0h exp=1", ep16); end
        total++; if (ec16 !== 3'd4) begin bad++; $display("FAIL rr16_cause got=%0d exp=4", ec16); end
        total++; if (epc16 !== 32'h40) begin bad++; $display("FAIL rr16_errpc got=%0h exp=40", epc16); end
        total++; if (dc16 !== 32'd0) begin bad++; $display("FAIL rr16_count got=%0d exp=0", dc16); end
        total++; if (b32.out_illegal !== 1'b0) begin bad++; $display("FAIL rr32_illegal got=%0h exp=0", b32.out_illegal); end
        total++; if (b32.out_kind !== 6'd28) begin bad++; $display("FAIL rr32_kind got=%0d exp=28", b32.out_kind); end
        total++; if (b32.out_rd !== 5'd17) begin bad++; $display("FAIL rr32_rd got=%0d exp=17", b32.out_rd); end
        total++; if (b32.out_rs1 !== 5'd0) begin bad++; $display("FAIL rr32_rs1 got=%0d exp=0", b32.out_rs1); end
        total++; if (b32.out_rs2 !== 5'd17) begin bad++; $display("FAIL rr32_rs2 got=%0d exp=17", b32.out_rs2); end
        total++; if (ep32 !== 1'b0) begin bad++; $display("FAIL rr32_pending got=%0h exp=0", ep32); end
        total++; if (dc32 !== 32'd1) begin bad++; $display("FAIL rr32_count got=%0d exp=1", dc32); end
    endtask

    task automatic test_full();
        do_reset();
        drv_valid = 1'b1; drv_data = ADDI_X1; drv_pc = 32'h200;
        total++; if (b16.in_ready !== 1'b1) begin bad++; $display("FAIL full_rdy0 got=%0h exp=1", b16.in_ready); end
        tick();
        drv_data = ADDI_X2; drv_pc = 32'h204;
        total++; if (b16.in_ready !== 1'b1) begin bad++; $display("FAIL full_rdy1 got=%0h exp=1", b16.in_ready); end
        tick();
        drv_data = ADDI_X3; drv_pc = 32'h208;
        total++; if (b16.in_ready !== 1'b0) begin bad++; $display("FAIL full_rdy2 got=%0h exp=0", b16.in_ready); end
        tick();
        total++; if (b16.in_ready !== 1'b0) begin bad++; $display("FAIL full_rdy3 got=%0h exp=0", b16.in_ready); end
        total++; if (b16.out_imm !== 32'd1) begin bad++; $display("FAIL full_head1 got=%0h exp=1", b16.out_imm); end
        drv_oready = 1'b1;
        total++; if (b16.in_ready !== 1'b0) begin bad++; $display("FAIL full_nopass got=%0h exp=0", b16.in_ready); end
        tick();
        total++; if (b16.out_imm !== 32'd2) begin bad++; $display("FAIL full_head2 got=%0h exp=2", b16.out_imm); end
        total++; if (b16.in_ready !== 1'b1) begin bad++; $display("FAIL full_rdy4 got=%0h exp=1", b16.in_ready); end
        tick();
        drv_valid = 1'b0;
        total++; if (b16.out_imm !== 32'd3) begin bad++; $display("FAIL full_head3 got=%0h exp=3", b16.out_imm); end
        total++; if (b16.out_rd !== 5'd3) begin bad++; $display("FAIL full_rd3 got=%0d exp=3", b16.out_rd); end
        total++; if (b16.out_pc !== 32'h208) begin bad++; $display("FAIL full_pc3 got=%0h exp=208", b16.out_pc); end
        tick();
        total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%0h exp=0", b16.out_valid); end
        total++; if (dc16 !== 32'd3) begin bad++; $display("FAIL full_count got=%0d exp=3", dc16); end
    endtask

    task automatic test_err_latch();
        do_reset();
        drv_oready = 1'b1; drv_valid = 1'b1; drv_data = BAD_OPC; drv_pc = 32'h10;
        tick();
        drv_data = 32'h00002063; drv_pc = 32'h14;
        tick();
        total++; if (ec16 !== 3'd1) begin bad++; $display("FAIL latch_cause got=%0d exp=1", ec16); end
        total++; if (epc16 !== 32'h10) begin bad++; $display("FAIL latch_pc got=%0h exp=10", epc16); end
        total++; if (b16.out_illegal !== 1'b1) begin bad++; $display("FAIL latch_beq_ill got=%0h exp=1", b16.out_illegal); end
        total++; if (b16.out_imm !== 32'h00002063) begin bad++; $display("FAIL latch_beq_imm got=%0h exp=2063", b16.out_imm); end
        drv_data = BAD_OPC; drv_pc = 32'h18; err_clear = 1'b1;
        tick();
        drv_valid = 1'b0; err_clear = 1'b0;
        total++; if (epc16 !== 32'h18) begin bad++; $display("FAIL latch_setwins_pc got=%0h exp=18", epc16); end
        total++; if (ep16 !== 1'b1) begin bad++; $display("FAIL latch_setwins_pend got=%0h exp=1", ep16); end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        total++; if (ep16 !== 1'b0) begin bad++; $display("FAIL latch_clr_pend got=%0h exp=0", ep16); end
        total++; if (ec16 !== 3'd0) begin bad++; $display("FAIL latch_clr_cause got=%0d exp=0", ec16); end
        total++; if (epc16 !== 32'd0) begin bad++; $display("FAIL latch_clr_pc got=%0h exp=0", epc16); end
        total++; if (dc16 !== 32'd0) begin bad++; $display("FAIL latch_count got=%0d exp=0", dc16); end
    endtask

    task automatic test_causes();
        do_reset();
        drv_oready = 1'b1; drv_valid = 1'b1; drv_data = 32'h40109093; drv_pc = 32'h50;
        tick();
        drv_valid = 1'b0;
        total++; if (ec16 !== 3'd3) begin bad++; $display("FAIL cause_slli got=%0d exp=3", ec16); end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0; drv_valid = 1'b1; drv_data = 32'h00003003; drv_pc = 32'h54;
        tick();
        drv_valid = 1'b0;
        total++; if (ec16 !== 3'd2) begin bad++; $display("FAIL cause_load got=%0d exp=2", ec16); end
        total++; if (epc16 !== 32'h54) begin bad++; $display("FAIL cause_load_pc got=%0h exp=54", epc16); end
    endtask

    task automatic test_err_stall();
        do_reset();
        drv_valid = 1'b1; drv_data = ADDI_X1; drv_pc = 32'h20;
        tick();
        drv_data = BAD_OPC; drv_pc = 32'h24;
        tick();
        drv_data = ADDI_X3; drv_pc = 32'h28;
        total++; if (epst !== 1'b1) begin bad++; $display("FAIL stall_pending got=%0h exp=1", epst); end
        total++; if (bst.in_ready !== 1'b0) begin bad++; $display("FAIL stall_rdy0 got=%0h exp=0", bst.in_ready); end
        drv_oready = 1'b1;
        tick();
        total++; if (bst.out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%0h exp=1", bst.out_valid); end
        total++; if (bst.out_illegal !== 1'b1) begin bad++; $display("FAIL stall_trap_head got=%0h exp=1", bst.out_illegal); end
        total++; if (bst.in_ready !== 1'b0) begin bad++; $display("FAIL stall_rdy1 got=%0h exp=0", bst.in_ready); end
        total++; if (dcst !== 32'd1) begin bad++; $display("FAIL stall_count1 got=%0d exp=1", dcst); end
        tick();
        total++; if (bst.out_valid !== 1'b0) begin bad++; $display("FAIL stall_drained got=%0h exp=0", bst.out_valid); end
        err_clear = 1'b1;
        total++; if (bst.in_ready !== 1'b0) begin bad++; $display("FAIL stall_rdy2 got=%0h exp=0", bst.in_ready); end
        tick();
        err_clear = 1'b0;
        total++; if (bst.in_ready !== 1'b1) begin bad++; $display("FAIL stall_rdy3 got=%0h exp=1", bst.in_ready); end
        tick();
        drv_valid = 1'b0;
        total++; if (bst.out_imm !== 32'd3) begin bad++; $display("FAIL stall_resume_imm got=%0h exp=3", bst.out_imm); end
        total++; if (bst.out_pc !== 32'h28) begin bad++; $display("FAIL stall_resume_pc got=%0h exp=28", bst.out_pc); end
        total++; if (dcst !== 32'd2) begin bad++; $display("FAIL stall_count2 got=%0d exp=2", dcst); end
    endtask

    task automatic test_flush();
        do_reset();
        drv_valid = 1'b1; drv_data = BAD_OPC; drv_pc = 32'h30;
        tick();
        drv_data = ADDI_X1; drv_pc = 32'h34;
        tick();
        drv_data = ADDI_X2; drv_pc = 32'h38; flush = 1'b1;
        total++; if (b16.in_ready !== 1'b0) begin bad++; $display("FAIL flush_rdy got=%0h exp=0", b16.in_ready); end
        tick();
        flush = 1'b0; drv_valid = 1'b0;
        total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0h exp=0", b16.out_valid); end
        total++; if (b16.out_imm !== 32'd0) begin bad++; $display("FAIL flush_imm got=%0h exp=0", b16.out_imm); end
        total++; if (dc16 !== 32'd1) begin bad++; $display("FAIL flush_count got=%0d exp=1", dc16); end
        total++; if (ep16 !== 1'b1) begin bad++; $display("FAIL flush_pending got=%0h exp=1", ep16); end
        total++; if (epc16 !== 32'h30) begin bad++; $display("FAIL flush_errpc got=%0h exp=30", epc16); end
        total++; if (ec16 !== 3'd1) begin bad++; $display("FAIL flush_cause got=%0d exp=1", ec16); end
        drv_valid = 1'b1; drv_data = ADDI_X3; drv_pc = 32'h3C;
        tick();
        drv_valid = 1'b0;
        total++; if (b16.out_imm !== 32'd3) begin bad++; $display("FAIL flush_after_imm got=%0h exp=3", b16.out_imm); end
        total++; if (b16.out_pc !== 32'h3C) begin bad++; $display("FAIL flush_after_pc got=%0h exp=3c", b16.out_pc); end
        total++; if (dc16 !== 32'd2) begin bad++; $display("FAIL flush_after_count got=%0d exp=2", dc16); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drv_oready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drv_valid = 1'b1; drv_data = BB_WORD[i]; drv_pc = 32'h300 + 32'(i * 4);
            tick();
            total++; if (b16.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%0h exp=1", i, b16.out_valid); end
            total++; if (b16.out_kind !== BB_KIND[i]) begin bad++; $display("FAIL b2b_kind[%0d] got=%0d exp=%0d", i, b16.out_kind, BB_KIND[i]); end
            total++; if (b16.out_rd !== BB_RD[i]) begin bad++; $display("FAIL b2b_rd[%0d] got=%0d exp=%0d", i, b16.out_rd, BB_RD[i]); end
            total++; if (b16.out_rs1 !== BB_RS1[i]) begin bad++; $display("FAIL b2b_rs1[%0d] got=%0d exp=%0d", i, b16.out_rs1, BB_RS1[i]); end
            total++; if (b16.out_rs2 !== BB_RS2[i]) begin bad++; $display("FAIL b2b_rs2[%0d] got=%0d exp=%0d", i, b16.out_rs2, BB_RS2[i]); end
            total++; if (b16.out_imm !== BB_IMM[i]) begin bad++; $display("FAIL b2b_imm[%0d] got=%0h exp=%0h", i, b16.out_imm, BB_IMM[i]); end
            total++; if (b16.out_illegal !== 1'b0) begin bad++; $display("FAIL b2b_illegal[%0d] got=%0h exp=0", i, b16.out_illegal); end
            total++; if (b16.out_pc !== 32'h300 + 32'(i * 4)) begin bad++; $display("FAIL b2b_pc[%0d] got=%0h", i, b16.out_pc); end
        end
        drv_valid = 1'b0;
        tick();
        total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0h exp=0", b16.out_valid); end
        total++; if (dc16 !== 32'd7) begin bad++; $display("FAIL b2b_count got=%0d exp=7", dc16); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_reg_range();
        test_full();
        test_err_latch();
        test_causes();
        test_err_stall();
        test_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
